// File: rtl/mtp_access_arb.sv
// mtp_access_arb: shares the single MTP access port between INIT, CMD_PARSE and OCU.
// Pulse requests are latched per requester and granted one at a time by fixed priority
// (INIT > PAR > OCU). Read data and done pulses come back tagged with the requester ID.
// Optional feature macro: MTP_ARB_TIMEOUT_EN adds a WAIT-state watchdog that reports
// acc_err after TMO_CYC cycles without mem_ack.

module mtp_access_arb #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TMO_CYC = 63
) (
    input  logic              DOUB_BLF,
    input  logic              rst_n,
    input  logic              new_cmd,
    input  logic              init_rd_pulse,
    input  logic [ADDR_W-1:0] init_pointer,
    input  logic              par_rd_pulse,
    input  logic [ADDR_W-1:0] par_pointer,
    input  logic              ocu_rd_pulse,
    input  logic              ocu_wr_pulse,
    input  logic [ADDR_W-1:0] ocu_pointer,
    input  logic [DATA_W-1:0] ocu_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mtp_data,
    output logic              rd_done,
    output logic              wr_done,
    output logic [1:0]        done_src,
    output logic              busy,
    output logic              acc_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_INIT = 2'b01;
    localparam logic [1:0] SRC_PAR  = 2'b10;
    localparam logic [1:0] SRC_OCU  = 2'b11;

    logic [1:0]        state_q, state_d;
    logic              init_pend_q, par_pend_q, ocu_pend_q;
    logic [ADDR_W-1:0] init_addr_q, par_addr_q, ocu_addr_q;
    logic              ocu_we_q;
    logic [DATA_W-1:0] ocu_wdata_q;
    logic [1:0]        gnt_q;
    logic              quiet_q;

    logic par_live, ocu_live;
    logic gnt_init, gnt_par, gnt_ocu, any_gnt;
    logic flush_active, quiet_now;
    logic tmo_hit;

    // new_cmd flushes PAR/OCU pending in the same cycle, so they may not win arbitration
    assign par_live = par_pend_q & ~new_cmd;
    assign ocu_live = ocu_pend_q & ~new_cmd;

    assign gnt_init = (state_q == ST_IDLE) & init_pend_q;
    assign gnt_par  = (state_q == ST_IDLE) & ~init_pend_q & par_live;
    assign gnt_ocu  = (state_q == ST_IDLE) & ~init_pend_q & ~par_live & ocu_live;
    assign any_gnt  = gnt_init | gnt_par | gnt_ocu;

    // An in-flight PAR/OCU access finishes on the MTP but its completion is not reported
    assign flush_active = new_cmd & (state_q != ST_IDLE) & (gnt_q != SRC_INIT);
    assign quiet_now    = quiet_q | flush_active;

    assign busy = (state_q != ST_IDLE);

    // Pending request latches; a new pulse wins over a same-cycle clear
    always_ff @(posedge DOUB_BLF or negedge rst_n) begin
        if (!rst_n) begin
            init_pend_q <= 1'b0;
            par_pend_q  <= 1'b0;
            ocu_pend_q  <= 1'b0;
            init_addr_q <= '0;
            par_addr_q  <= '0;
            ocu_addr_q  <= '0;
            ocu_we_q    <= 1'b0;
            ocu_wdata_q <= '0;
        end else begin
            init_pend_q <= init_rd_pulse | (init_pend_q & ~gnt_init);
            par_pend_q  <= par_rd_pulse | (par_pend_q & ~gnt_par & ~new_cmd);
            ocu_pend_q  <= ocu_rd_pulse | ocu_wr_pulse | (ocu_pend_q & ~gnt_ocu & ~new_cmd);
            if (init_rd_pulse) begin
                init_addr_q <= init_pointer;
            end
            if (par_rd_pulse) begin
                par_addr_q <= par_pointer;
            end
            // Simultaneous OCU read and write: keep the write
            if (ocu_wr_pulse) begin
                ocu_addr_q  <= ocu_pointer;
                ocu_we_q    <= 1'b1;
                ocu_wdata_q <= ocu_wdata;
            end else if (ocu_rd_pulse) begin
                ocu_addr_q <= ocu_pointer;
                ocu_we_q   <= 1'b0;
            end
        end
    end

    // Access sequencing: IDLE -> ISSUE -> WAIT -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_gnt) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mem_ack || tmo_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge DOUB_BLF or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant latch, memory-side outputs, read data and done pulses
    always_ff @(posedge DOUB_BLF or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= SRC_NONE;
            quiet_q   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mtp_data  <= '0;
            rd_done   <= 1'b0;
            wr_done   <= 1'b0;
            done_src  <= SRC_NONE;
        end else begin
            mem_req  <= (state_q == ST_ISSUE);
            rd_done  <= 1'b0;
            wr_done  <= 1'b0;
            done_src <= SRC_NONE;

            if (any_gnt) begin
                gnt_q     <= gnt_init ? SRC_INIT : (gnt_par ? SRC_PAR : SRC_OCU);
                mem_addr  <= gnt_init ? init_addr_q : (gnt_par ? par_addr_q : ocu_addr_q);
                mem_we    <= gnt_ocu & ocu_we_q;
                mem_wdata <= (gnt_ocu && ocu_we_q) ? ocu_wdata_q : '0;
                quiet_q   <= 1'b0;
            end else if (flush_active) begin
                quiet_q <= 1'b1;
            end

            if ((state_q == ST_WAIT) && !mem_we) begin
                if (mem_ack) begin
                    mtp_data <= mem_rdata;
                end else if (tmo_hit) begin
                    mtp_data <= '1;
                end
            end

            if ((state_q == ST_DONE) && !quiet_now) begin
                rd_done  <= ~mem_we;
                wr_done  <= mem_we;
                done_src <= gnt_q;
            end
        end
    end

`ifdef MTP_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_q;

    // mem_ack in the last allowed WAIT cycle still counts as a normal completion
    assign tmo_hit = (state_q == ST_WAIT) & ~mem_ack & (tmo_cnt_q == TMO_LAST);

    // WAIT-state watchdog and error pulse
    always_ff @(posedge DOUB_BLF or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            acc_err   <= 1'b0;
        end else begin
            acc_err <= 1'b0;
            if (state_q == ST_ISSUE) begin
                tmo_cnt_q <= '0;
                tmo_q     <= 1'b0;
            end else if ((state_q == ST_WAIT) && !mem_ack) begin
                if (tmo_hit) begin
                    tmo_q <= 1'b1;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
            end
            if (state_q == ST_DONE) begin
                acc_err <= tmo_q & ~quiet_now;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign acc_err = 1'b0;
`endif

endmodule

// File: tb/tb_mtp_access_arb.sv
// Self-checking bench for mtp_access_arb: directed vector table, hand-written corner
// sequences, then randomized traffic compared against a transaction-level reference model.

module tb_mtp_access_arb;

    localparam int TMO = 63;
`ifdef MTP_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        DOUB_BLF;
    logic        rst_n;
    logic        new_cmd;
    logic        init_rd_pulse;
    logic [4:0]  init_pointer;
    logic        par_rd_pulse;
    logic [4:0]  par_pointer;
    logic        ocu_rd_pulse;
    logic        ocu_wr_pulse;
    logic [4:0]  ocu_pointer;
    logic [15:0] ocu_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mtp_data;
    logic        rd_done;
    logic        wr_done;
    logic [1:0]  done_src;
    logic        busy;
    logic        acc_err;

    int checks = 0;
    int errors = 0;

    mtp_access_arb #(
        .ADDR_W  (5),
        .DATA_W  (16),
        .TMO_CYC (TMO)
    ) dut (
        .DOUB_BLF      (DOUB_BLF),
        .rst_n         (rst_n),
        .new_cmd       (new_cmd),
        .init_rd_pulse (init_rd_pulse),
        .init_pointer  (init_pointer),
        .par_rd_pulse  (par_rd_pulse),
        .par_pointer   (par_pointer),
        .ocu_rd_pulse  (ocu_rd_pulse),
        .ocu_wr_pulse  (ocu_wr_pulse),
        .ocu_pointer   (ocu_pointer),
        .ocu_wdata     (ocu_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mtp_data      (mtp_data),
        .rd_done       (rd_done),
        .wr_done       (wr_done),
        .done_src      (done_src),
        .busy          (busy),
        .acc_err       (acc_err)
    );

    initial begin
        DOUB_BLF = 1'b0;
        forever #5 DOUB_BLF = ~DOUB_BLF;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge DOUB_BLF);
        #1;
    endtask

    task automatic clear_inputs();
        new_cmd = 0; init_rd_pulse = 0; par_rd_pulse = 0; ocu_rd_pulse = 0; ocu_wr_pulse = 0;
        init_pointer = 0; par_pointer = 0; ocu_pointer = 0; ocu_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    // sel: 1=INIT read, 2=PAR read, 3=OCU read, 4=OCU write
    task automatic fire(input int sel, input logic [4:0] a, input logic [15:0] wd);
        init_pointer = a; par_pointer = a; ocu_pointer = a; ocu_wdata = wd;
        init_rd_pulse = (sel == 1); par_rd_pulse = (sel == 2);
        ocu_rd_pulse = (sel == 3); ocu_wr_pulse = (sel == 4);
        tick();
        init_rd_pulse = 0; par_rd_pulse = 0; ocu_rd_pulse = 0; ocu_wr_pulse = 0;
    endtask

    typedef struct {
        int          sel;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
        logic        exp_we;
        logic [1:0]  exp_src;
        logic [15:0] exp_mtp;
    } vec_t;

    vec_t vecs[5];

    // ---------------- reference model state ----------------
    bit          m_pend[1:3];
    logic [4:0]  m_paddr[1:3];
    logic        m_owe;
    logic [15:0] m_owd;
    int          m_phase;  // 0 idle, 1 issuing, 2 waiting for ack, 3 completing
    int          m_cur;
    logic        m_cwe;
    logic [4:0]  m_caddr;
    logic [15:0] m_cwd;
    bit          m_quiet, m_tmo;
    int          m_wcnt;
    logic [15:0] m_mtp;
    logic        e_req, e_rd, e_wr, e_err;
    logic [1:0]  e_src;

    task automatic model_reset();
        for (int i = 1; i <= 3; i++) begin m_pend[i] = 0; m_paddr[i] = 0; end
        m_owe = 0; m_owd = 0; m_phase = 0; m_cur = 0; m_cwe = 0; m_caddr = 0; m_cwd = 0;
        m_quiet = 0; m_tmo = 0; m_wcnt = 0; m_mtp = 0;
        e_req = 0; e_rd = 0; e_wr = 0; e_err = 0; e_src = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        int granted;
        bit flush;
        granted = 0;
        flush = new_cmd && (m_phase != 0) && (m_cur > 1);
        e_req = 0; e_rd = 0; e_wr = 0; e_err = 0; e_src = 0;
        case (m_phase)
            0: begin
                for (int i = 1; i <= 3; i++)
                    if (granted == 0 && m_pend[i] && !(new_cmd && i > 1)) granted = i;
                if (granted != 0) begin
                    m_cur = granted; m_caddr = m_paddr[granted];
                    m_cwe = (granted == 3) && m_owe;
                    m_cwd = m_cwe ? m_owd : 16'h0;
                    m_quiet = 0; m_tmo = 0; m_phase = 1;
                end
            end
            1: begin e_req = 1; m_phase = 2; m_wcnt = 0; end
            2: begin
                if (mem_ack) begin
                    if (!m_cwe) m_mtp = mem_rdata;
                    m_phase = 3;
                end else if (TMO_EN && m_wcnt == TMO - 1) begin
                    m_tmo = 1;
                    if (!m_cwe) m_mtp = 16'hFFFF;
                    m_phase = 3;
                end else begin
                    m_wcnt++;
                end
            end
            default: begin
                if (!(m_quiet || flush)) begin
                    e_rd = !m_cwe; e_wr = m_cwe; e_src = 2'(m_cur); e_err = m_tmo;
                end
                m_phase = 0;
            end
        endcase
        if (flush) m_quiet = 1;
        for (int i = 1; i <= 3; i++)
            if (granted == i || (new_cmd && i > 1)) m_pend[i] = 0;
        if (init_rd_pulse) begin m_pend[1] = 1; m_paddr[1] = init_pointer; end
        if (par_rd_pulse) begin m_pend[2] = 1; m_paddr[2] = par_pointer; end
        if (ocu_wr_pulse) begin
            m_pend[3] = 1; m_paddr[3] = ocu_pointer; m_owe = 1; m_owd = ocu_wdata;
        end else if (ocu_rd_pulse) begin
            m_pend[3] = 1; m_paddr[3] = ocu_pointer; m_owe = 0;
        end
    endtask

    initial begin
        int n;
        int nreq, ndone, nwr;
        bit started, seen;
        logic [4:0] req_addr[$];
        logic [1:0] src_seen[$];

        vecs[0] = '{1, 5'h03, 16'h0000, 16'hA5C3, 0,  1'b0, 2'b01, 16'hA5C3};
        vecs[1] = '{4, 5'h1F, 16'h1234, 16'hBEEF, 10, 1'b1, 2'b11, 16'hA5C3};
        vecs[2] = '{2, 5'h0A, 16'h0000, 16'h5A5A, 2,  1'b0, 2'b10, 16'h5A5A};
        vecs[3] = '{3, 5'h11, 16'h0000, 16'h0F0F, 1,  1'b0, 2'b11, 16'h0F0F};
        vecs[4] = '{1, 5'h00, 16'h0000, 16'hFFFF, 5,  1'b0, 2'b01, 16'hFFFF};

        clear_inputs();
        rst_n = 0;
        #3;
        chk("reset_outputs",
            {mem_req, mem_we, mem_addr, mem_wdata, mtp_data, rd_done, wr_done, done_src,
             busy, acc_err}, 64'h0);
        tick(); tick();
        rst_n = 1;
        tick();

        // ---------------- directed single-access vectors ----------------
        for (int v = 0; v < 5; v++) begin
            fire(vecs[v].sel, vecs[v].addr, vecs[v].wdata);
            chk("req_early_e0", mem_req, 0);
            tick();
            chk("busy_issue", busy, 1);
            chk("req_early_e1", mem_req, 0);
            tick();
            chk("req_strobe", mem_req, 1);
            chk("req_addr", mem_addr, vecs[v].addr);
            chk("req_we", mem_we, vecs[v].exp_we);
            if (vecs[v].exp_we) chk("req_wdata", mem_wdata, vecs[v].wdata);
            for (int d = 0; d < vecs[v].delay; d++) begin
                tick();
                chk("req_single", mem_req, 0);
                chk("addr_hold", mem_addr, vecs[v].addr);
                if (vecs[v].exp_we) chk("wdata_hold", mem_wdata, vecs[v].wdata);
                chk("no_done_wait", {rd_done, wr_done}, 0);
            end
            mem_ack = 1; mem_rdata = vecs[v].rdata;
            tick();
            mem_ack = 0; mem_rdata = 16'h7777;
            chk("no_done_yet", {rd_done, wr_done}, 0);
            tick();
            chk("rd_done", rd_done, !vecs[v].exp_we);
            chk("wr_done", wr_done, vecs[v].exp_we);
            chk("done_src", done_src, vecs[v].exp_src);
            chk("mtp_data", mtp_data, vecs[v].exp_mtp);
            chk("acc_err_off", acc_err, 0);
            chk("busy_end", busy, 0);
            tick();
            chk("done_single", {rd_done, wr_done, done_src}, 0);
        end

        // ---------------- three simultaneous requests ----------------
        init_pointer = 5'h01; par_pointer = 5'h02; ocu_pointer = 5'h03;
        init_rd_pulse = 1; par_rd_pulse = 1; ocu_rd_pulse = 1;
        tick();
        init_rd_pulse = 0; par_rd_pulse = 0; ocu_rd_pulse = 0;
        mem_ack = 1; mem_rdata = 16'hC0DE;
        nreq = 0; ndone = 0; nwr = 0; started = 0;
        for (int c = 0; c < 60 && ndone < 3; c++) begin
            tick();
            if (busy) started = 1;
            if (mem_req) begin req_addr.push_back(mem_addr); chk("busy_at_req", busy, 1); end
            if (rd_done) begin src_seen.push_back(done_src); ndone++; end
            if (wr_done) nwr++;
            if (started && ndone < 3) chk("busy_throughout", busy, !rd_done);
        end
        mem_ack = 0;
        chk("multi_req_count", req_addr.size(), 3);
        chk("multi_done_count", src_seen.size(), 3);
        chk("multi_no_wr", nwr, 0);
        for (int i = 0; i < 3 && i < req_addr.size(); i++) chk("multi_order", req_addr[i], i + 1);
        for (int i = 0; i < 3 && i < src_seen.size(); i++) chk("multi_src", src_seen[i], i + 1);
        tick();

        // ---------------- new_cmd flush during PAR access ----------------
        fire(2, 5'h04, 16'h0);
        tick(); tick();
        chk("flush_req", mem_req, 1);
        chk("flush_addr", mem_addr, 5'h04);
        ocu_pointer = 5'h05; ocu_rd_pulse = 1;
        tick();
        ocu_rd_pulse = 0; new_cmd = 1;
        tick();
        new_cmd = 0; mem_ack = 1; mem_rdata = 16'h1357;
        tick();
        mem_ack = 0;
        tick();
        chk("flush_no_done", {rd_done, wr_done, done_src}, 0);
        chk("flush_mtp", mtp_data, 16'h1357);
        chk("flush_busy", busy, 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_req || busy || rd_done) seen = 1;
        end
        chk("flush_ocu_dropped", seen, 0);

        // ---------------- asynchronous reset during WAIT ----------------
        fire(1, 5'h07, 16'h0);
        tick(); tick(); tick();
        chk("rst_in_wait", busy, 1);
        #1 rst_n = 0;
        #1;
        chk("rst_outputs",
            {mem_req, mem_we, mem_addr, mem_wdata, mtp_data, rd_done, wr_done, done_src,
             busy, acc_err}, 64'h0);
        rst_n = 1;
        mem_ack = 1; mem_rdata = 16'h9999;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rd_done || wr_done || mem_req || busy) seen = 1;
        end
        mem_ack = 0;
        chk("rst_late_ack", seen, 0);
        chk("rst_mtp", mtp_data, 16'h0);

`ifdef MTP_ARB_TIMEOUT_EN
        // ---------------- watchdog timeout ----------------
        fire(1, 5'h09, 16'h0);
        tick(); tick();
        chk("tmo_req", mem_req, 1);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            n++;
            if (rd_done) break;
        end
        chk("tmo_cycles", n, TMO + 1);
        chk("tmo_err", acc_err, 1);
        chk("tmo_rd_done", rd_done, 1);
        chk("tmo_src", done_src, 2'b01);
        chk("tmo_mtp", mtp_data, 16'hFFFF);
        tick();
        chk("tmo_err_single", acc_err, 0);
        chk("tmo_idle", busy, 0);
        mem_ack = 1;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rd_done || acc_err) seen = 1;
        end
        mem_ack = 0;
        chk("tmo_late_ack", seen, 0);
`endif

        // ---------------- randomized traffic vs reference model ----------------
        clear_inputs();
        rst_n = 0;
        #2;
        rst_n = 1;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            init_rd_pulse = ($urandom_range(0, 99) < 6);
            par_rd_pulse  = ($urandom_range(0, 99) < 8);
            ocu_rd_pulse  = ($urandom_range(0, 99) < 6);
            ocu_wr_pulse  = ($urandom_range(0, 99) < 6);
            new_cmd       = ($urandom_range(0, 99) < 3);
            mem_ack       = ($urandom_range(0, 99) < 35);
            init_pointer  = 5'($urandom);
            par_pointer   = 5'($urandom);
            ocu_pointer   = 5'($urandom);
            ocu_wdata     = 16'($urandom);
            mem_rdata     = 16'($urandom);
            model_step();
            tick();
            chk("rnd_req", mem_req, e_req);
            chk("rnd_rd_done", rd_done, e_rd);
            chk("rnd_wr_done", wr_done, e_wr);
            chk("rnd_src", done_src, e_src);
            chk("rnd_err", acc_err, e_err);
            chk("rnd_busy", busy, m_phase != 0);
            chk("rnd_mtp", mtp_data, m_mtp);
            if (m_phase == 2) begin
                chk("rnd_addr", mem_addr, m_caddr);
                chk("rnd_we", mem_we, m_cwe);
                if (m_cwe) chk("rnd_wdata", mem_wdata, m_cwd);
            end
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
